// File: rtl/delay_echo.sv
// Sample-rate echo/delay effect: y = x + (gain/16) * delayed sample, with optional feedback.
// Build option: define DELAY_SAT_EN to saturate the sum; otherwise it wraps in two's complement.
module delay_echo #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 12,
    parameter int GAIN_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ready,
    input  logic signed [WIDTH-1:0]  x,
    input  logic        [ADDR_W-1:0] delay_len,
    input  logic        [GAIN_W-1:0] gain,
    input  logic                     feedback,
    output logic signed [WIDTH-1:0]  y,
    output logic                     done,
    output logic                     overrun
);

    localparam int PW    = WIDTH + GAIN_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] FILL_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] LEN_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        MAC  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t                    r_state;
    logic signed [WIDTH-1:0]   r_x;
    logic        [GAIN_W-1:0]  r_gain;
    logic                      r_fb;
    logic        [ADDR_W-1:0]  r_len;
    logic        [ADDR_W-1:0]  r_rd_addr;
    logic        [ADDR_W-1:0]  r_wr_ptr;
    logic        [ADDR_W-1:0]  r_fill;
    logic signed [WIDTH-1:0]   r_res;
    logic signed [WIDTH-1:0]   r_y;
    logic                      r_done;
    logic                      r_overrun;
    logic signed [WIDTH-1:0]   r_ram_q;
    logic signed [WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic        [ADDR_W-1:0]  w_len;
    logic signed [WIDTH-1:0]   w_tap;
    logic signed [PW-1:0]      w_prod;
    logic signed [WIDTH:0]     w_sum;
    logic signed [WIDTH-1:0]   w_res;

    assign w_len = (delay_len == {ADDR_W{1'b0}}) ? LEN_ONE : delay_len;

    // Until enough samples have been written the tap would read stale RAM, so force it to zero.
    assign w_tap  = (r_fill < r_len) ? {WIDTH{1'b0}} : r_ram_q;
    assign w_prod = PW'(w_tap) * PW'($signed({1'b0, r_gain}));
    assign w_sum  = (WIDTH+1)'(PW'(r_x) + (w_prod >>> GAIN_W));

`ifdef DELAY_SAT_EN
    localparam logic signed [WIDTH:0] SUM_MAX = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] SUM_MIN = {2'b11, {(WIDTH-1){1'b0}}};

    // Clamp the widened sum into the signed sample range.
    always_comb begin
        w_res = WIDTH'(w_sum);
        if (w_sum > SUM_MAX) begin
            w_res = WIDTH'(SUM_MAX);
        end else if (w_sum < SUM_MIN) begin
            w_res = WIDTH'(SUM_MIN);
        end else begin
            w_res = WIDTH'(w_sum);
        end
    end
`else
    assign w_res = WIDTH'(w_sum);
`endif

    // Sequencer: accept a sample, read the tap, multiply-accumulate, then write back and publish.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_x       <= {WIDTH{1'b0}};
            r_gain    <= {GAIN_W{1'b0}};
            r_fb      <= 1'b0;
            r_len     <= LEN_ONE;
            r_rd_addr <= {ADDR_W{1'b0}};
            r_wr_ptr  <= {ADDR_W{1'b0}};
            r_fill    <= {ADDR_W{1'b0}};
            r_res     <= {WIDTH{1'b0}};
            r_y       <= {WIDTH{1'b0}};
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (ready && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (ready) begin
                        r_x       <= x;
                        r_gain    <= gain;
                        r_fb      <= feedback;
                        r_len     <= w_len;
                        r_rd_addr <= r_wr_ptr - w_len;
                        r_state   <= RD;
                    end
                end
                RD: begin
                    r_state <= MAC;
                end
                MAC: begin
                    r_res   <= w_res;
                    r_state <= WR;
                end
                WR: begin
                    r_y      <= r_res;
                    r_done   <= 1'b1;
                    r_wr_ptr <= r_wr_ptr + LEN_ONE;
                    if (r_fill != FILL_MAX) begin
                        r_fill <= r_fill + LEN_ONE;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Delay-line RAM: contents survive reset; reset forces IDLE so an in-flight write never lands.
    always_ff @(posedge clk) begin
        if (r_state == WR) begin
            r_mem[r_wr_ptr] <= r_fb ? r_res : r_x;
        end
        if (r_state == RD) begin
            r_ram_q <= r_mem[r_rd_addr];
        end
    end

    assign y       = r_y;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule
